rsa_modexp_ctrl: RTL and testbench

- Modular exponentiation sequencer that sits directly upstream of the Montgomery multiplier (MONT_TOP) and drives it.
- Computes result = msg^exp mod n by left-to-right square-and-multiply.
- Issues one Montgomery product at a time over the multiplier's x/y/n/rst/enable/finish/result interface, with R = 2^WIDTH.
- Performs domain conversion on entry and exit. Caller supplies r2 = R^2 mod n.

---
 rtl/rsa_modexp_ctrl.sv | 148 ++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Optional MODEXP_SKIP_LZ_EN: extra LOAD cycle starts the scan at the exponent MSB.
module rsa_modexp_ctrl #(
  parameter int WIDTH = 2048,
  parameter int EXP_WIDTH = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  input  logic [WIDTH-1:0]     r2,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [15:0]          mult_cnt,
  output logic                 mont_rst,
  output logic                 mont_enable,
  output logic [WIDTH-1:0]     mont_x,
  output logic [WIDTH-1:0]     mont_y,
  output logic [WIDTH-1:0]     mont_n,
  input  logic                 mont_finish,
  input  logic [WIDTH-1:0]     mont_result
);
  localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  typedef enum logic [2:0] {IDLE, LOAD, PRE_M, PRE_A, SQR, MUL, POST, FIN} state_t;
  state_t state_q, state_d;
  logic run_q, run_d;
  logic [WIDTH-1:0] msg_q, msg_d, n_q, n_d, r2_q, r2_d, mbar_q, mbar_d, acc_q, acc_d, res_q, res_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [15:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic prod, last;
  state_t step;
`ifdef MODEXP_SKIP_LZ_EN
  logic [IW-1:0] msb;
  always_comb begin
    msb = '0;
    for (int k = 0; k < EXP_WIDTH; k++)
      if (exp_q[k]) msb = IW'(k);
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      msg_q   <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      r2_q    <= '0;
      mbar_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      r2_q    <= r2_d;
      mbar_q  <= mbar_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    msg_d = msg_q;
    exp_d = exp_q;
    n_d = n_q;
    r2_d = r2_q;
    mbar_d = mbar_q;
    acc_d = acc_q;
    res_d = res_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    mont_rst = 1'b0;
    mont_enable = 1'b0;
    mont_x = '0;
    mont_y = '0;
    mont_n = '0;
    prod = state_q inside {PRE_M, PRE_A, SQR, MUL, POST};
    last = idx_q == '0;
    step = last ? POST : SQR;
    if (prod) begin
      mont_n = n_q;
      mont_x = state_q == PRE_M ? msg_q : state_q == PRE_A ? ONE : acc_q;
      mont_y = state_q inside {PRE_M, PRE_A} ? r2_q : state_q == MUL ? mbar_q : state_q == POST ? ONE : acc_q;
      mont_rst = !run_q;
      mont_enable = run_q;
      if (!run_q) begin
        run_d = 1'b1;
        cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
      end
    end
    case (state_q)
      IDLE: if (start) begin
        msg_d = msg;
        exp_d = exp;
        n_d = n;
        r2_d = r2;
        cnt_d = '0;
        idx_d = IW'(EXP_WIDTH - 1);
`ifdef MODEXP_SKIP_LZ_EN
        state_d = LOAD;
`else
        state_d = PRE_M;
`endif
      end
      LOAD: begin
`ifdef MODEXP_SKIP_LZ_EN
        idx_d = msb;
`endif
        state_d = PRE_M;
      end
      FIN: state_d = IDLE;
      default: if (run_q && mont_finish) begin
        run_d = 1'b0;
        if (state_q == PRE_M) mbar_d = mont_result;
        else if (state_q == POST) res_d = mont_result;
        else acc_d = mont_result;
        if (state_q inside {SQR, MUL} && !(state_q == SQR && exp_q[idx_q]) && !last) idx_d = idx_q - 1'b1;
        case (state_q)
          PRE_M: state_d = PRE_A;
`ifdef MODEXP_SKIP_LZ_EN
          PRE_A: state_d = exp_q == '0 ? POST : SQR;
`else
          PRE_A: state_d = SQR;
`endif
          SQR: state_d = exp_q[idx_q] ? MUL : step;
          MUL: state_d = step;
          default: state_d = FIN;
        endcase
      end
    endcase
  end
  assign busy = !(state_q inside {IDLE, FIN});
  assign done = state_q == FIN;
  assign result = res_q;
  assign mult_cnt = cnt_q;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl: directed vectors against a 5-cycle behavioural Montgomery multiplier (R=256, n=13).
module tb_rsa_modexp_ctrl;
  localparam int W = 8;
  localparam int E = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] msg = '0, n = 8'd13, r2 = 8'd3;
  logic [E-1:0] exp = '0;
  logic busy, done, mont_rst, mont_enable, mont_finish;
  logic [W-1:0] result, mont_x, mont_y, mont_n, mont_result;
  logic [15:0] mult_cnt;
  int checks = 0, failures = 0;
  int rinv;
  always #5 clk = ~clk;
  rsa_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .exp(exp), .n(n), .r2(r2),
    .busy(busy), .done(done), .result(result), .mult_cnt(mult_cnt),
    .mont_rst(mont_rst), .mont_enable(mont_enable), .mont_x(mont_x), .mont_y(mont_y),
    .mont_n(mont_n), .mont_finish(mont_finish), .mont_result(mont_result)
  );
  int mcnt;
  logic fin_q, glitch = 1'b0;
  logic [W-1:0] mres;
  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      fin_q <= 1'b0;
      mres <= '0;
    end else if (mont_rst) begin
      mcnt <= 0;
      fin_q <= 1'b0;
      mres <= W'((int'(mont_x) * int'(mont_y) * rinv) % int'(mont_n));
    end else if (mont_enable) begin
      mcnt <= mcnt + 1;
      fin_q <= mcnt == 3;
    end else fin_q <= 1'b0;
  end
  assign mont_finish = fin_q | glitch;
  assign mont_result = mres;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  logic p_rst = 1'b0, p_en = 1'b0, p_fin = 1'b0;
  logic [3*W-1:0] p_ops = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mont_enable && !p_en) chk("hs_rst_before_en", {31'd0, p_rst}, 32'd1);
      if (mont_enable && p_en) chk("hs_operands_stable", {8'd0, mont_x, mont_y, mont_n}, {8'd0, p_ops});
      if (p_en && p_fin) chk("hs_en_drop_after_finish", {31'd0, mont_enable}, 32'd0);
    end
    p_rst <= mont_rst;
    p_en <= mont_enable;
    p_fin <= mont_finish;
    p_ops <= {mont_x, mont_y, mont_n};
  end
  task automatic check_zero(input string nm);
    chk(nm, {6'd0, busy, done, mont_rst, mont_enable, mult_cnt}, 32'd0);
    chk({nm, "_data"}, {result, mont_x, mont_y, mont_n}, 32'd0);
  endtask
  task automatic run(input logic [W-1:0] m, input logic [E-1:0] e, input logic [W-1:0] res,
                     input int cnt, input bit disturb);
    int dones = 0;
    bit glitched = 0;
    logic [W-1:0] got_res = '0;
    logic [15:0] got_cnt = '0;
    logic busy_at_done = 1'b1;
    @(negedge clk);
    msg = m;
    exp = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("cnt_cleared", {16'd0, mult_cnt}, 32'd0);
    for (int c = 0; c < 2000 && dones == 0; c++) begin
      @(negedge clk);
      glitch = 1'b0;
      if (done) begin
        dones++;
        got_res = result;
        got_cnt = mult_cnt;
        busy_at_done = busy;
      end
      if (disturb) begin
        start = c == 20;
        if (c == 20) begin
          msg = 8'd3;
          exp = 8'hFF;
        end
        if (c > 30 && mont_rst && !glitched) begin
          glitch = 1'b1;
          glitched = 1;
        end
      end
    end
    start = 1'b0;
    chk("done_seen", dones, 1);
    chk("result", {24'd0, got_res}, {24'd0, res});
    chk("mult_cnt", {16'd0, got_cnt}, cnt);
    chk("busy_low_at_done", {31'd0, busy_at_done}, 32'd0);
    @(negedge clk);
    chk("done_single_pulse", {30'd0, done, busy}, 32'd0);
    chk("result_held", {24'd0, result}, {24'd0, res});
  endtask
  typedef struct {
    logic [W-1:0] m;
    logic [E-1:0] e;
    logic [W-1:0] res;
    int cnt;
  } vec_t;
  vec_t v[5];
  initial begin
    rinv = 0;
    for (int k = 1; k < 13; k++) if ((256 * k) % 13 == 1) rinv = k;
`ifdef MODEXP_SKIP_LZ_EN
    v[0] = '{8'd7, 8'd5, 8'd11, 8};
    v[1] = '{8'd7, 8'd0, 8'd1, 3};
    v[2] = '{8'd2, 8'hFF, 8'd8, 19};
    v[3] = '{8'd3, 8'h80, 8'd9, 12};
    v[4] = '{8'd12, 8'd1, 8'd12, 5};
`else
    v[0] = '{8'd7, 8'd5, 8'd11, 13};
    v[1] = '{8'd7, 8'd0, 8'd1, 11};
    v[2] = '{8'd2, 8'hFF, 8'd8, 19};
    v[3] = '{8'd3, 8'h80, 8'd9, 12};
    v[4] = '{8'd12, 8'd1, 8'd12, 12};
`endif
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run(v[i].m, v[i].e, v[i].res, v[i].cnt, 0);
    run(8'd7, 8'd5, 8'd11, v[0].cnt, 1);
    @(negedge clk);
    msg = 8'd7;
    exp = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < 500 && !hit; c++) begin
        @(negedge clk);
        hit = mult_cnt == 16'd3 && mont_enable;
      end
      chk("reached_sqr_run", {31'd0, hit}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check_zero("async_abort");
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle_after_abort");
    run(8'd7, 8'd5, 8'd11, v[0].cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
